program_loader: RTL and testbench

- Writer-side counterpart to the CPU's instruction fetch path: receives a framed byte stream and writes it into the 16x8 instruction memory's write port.
- Holds the CPU stopped (`cpu_run`=0) while loading. Releases it only after a complete frame with a valid checksum.
- Sits between an external byte source (valid/ready) and the instruction memory write port plus the CPU run/reset gating.

---
 rtl/program_loader.sv | 136 +++++++++++++
 tb/tb_program_loader.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Framed byte-stream loader for the instruction memory write port.
// Accepts LEN / data / CSUM frames and releases the CPU only after a valid checksum.
module program_loader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              load_start,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [DATA_W-1:0] im_data,
  output logic              cpu_run,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  typedef enum logic [2:0] {
    S_LEN,
    S_DATA,
    S_CSUM,
    S_RUN,
    S_ERROR
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] len_q;
  logic [DATA_W-1:0] sum_q;
  logic [ADDR_W:0]   cnt_inc;
  logic              in_frame;
  logic              xfer;
  logic              last_data;
  logic              csum_ok;

  logic              vld_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [DATA_W-1:0] data_p1;

  // Running checksum wraps modulo 2**DATA_W.
  function automatic logic [DATA_W-1:0] sum_add(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    return a + b;
  endfunction

  function automatic logic len_ok(input logic [DATA_W-1:0] b);
    return (b != '0) && (b <= DATA_W'(DEPTH));
  endfunction

  assign in_frame  = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
  assign in_ready  = in_frame && !load_start;
  assign busy      = in_frame;
  assign xfer      = in_valid && in_ready;
  assign cnt_inc   = count + 1'b1;
  assign last_data = ({{(DATA_W-ADDR_W-1){1'b0}}, cnt_inc} == len_q);
  assign csum_ok   = (sum_add(sum_q, in_data) == '0);

  always_comb begin
    state_nxt = state;
    if (load_start) begin
      state_nxt = S_LEN;
    end else if (xfer) begin
      case (state)
        S_LEN:   state_nxt = len_ok(in_data) ? S_DATA : S_ERROR;
        S_DATA:  state_nxt = last_data ? S_CSUM : S_DATA;
        S_CSUM:  state_nxt = csum_ok ? S_RUN : S_ERROR;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_LEN;
    else      state <= state_nxt;
  end

  // Stage p1: registered memory write and frame status
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
      count   <= '0;
      cpu_run <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      vld_p1 <= xfer && (state == S_DATA);
      if (xfer && (state == S_DATA)) begin
        addr_p1 <= count[ADDR_W-1:0];
        data_p1 <= in_data;
      end
      if (load_start) begin
        count   <= '0;
        cpu_run <= 1'b0;
        done    <= 1'b0;
        err     <= 1'b0;
      end else if (xfer) begin
        case (state)
          S_LEN: begin
            count <= '0;
            if (!len_ok(in_data)) err <= 1'b1;
          end
          S_DATA: count <= cnt_inc;
          S_CSUM: begin
            cpu_run <= csum_ok;
            done    <= csum_ok;
            err     <= !csum_ok;
          end
          default: ;
        endcase
      end
    end
  end

  // Frame length and checksum accumulator are always reloaded by the LEN byte
  always_ff @(posedge clk) begin
    if (xfer && (state == S_LEN)) begin
      len_q <= in_data;
      sum_q <= in_data;
    end else if (xfer && (state == S_DATA)) begin
      sum_q <= sum_add(sum_q, in_data);
    end
  end

  assign im_we   = vld_p1;
  assign im_addr = addr_p1;
  assign im_data = data_p1;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: expected memory writes are queued as bytes
// are driven and checked against the write port as the pulses appear.
module tb_program_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       load_start = 1'b0;
  logic       im_we;
  logic [3:0] im_addr;
  logic [7:0] im_data;
  logic       cpu_run;
  logic       busy;
  logic       done;
  logic       err;
  logic [4:0] count;

  int errors = 0;
  int checks = 0;
  logic [11:0] exp_q[$];
  logic [7:0]  run_sum;

  program_loader #(.ADDR_W(4), .DATA_W(8), .DEPTH(16)) dut (
    .clk       (clk),
    .rst       (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .load_start(load_start),
    .im_we     (im_we),
    .im_addr   (im_addr),
    .im_data   (im_data),
    .cpu_run   (cpu_run),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (im_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {20'h0, im_addr, im_data}, 32'hFFFF_FFFF);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        check("write_addr_data", {20'h0, im_addr, im_data}, {20'h0, e});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_len(input logic [7:0] b);
    run_sum  = b;
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_data(input logic [3:0] addr, input logic [7:0] b);
    exp_q.push_back({addr, b});
    run_sum  = run_sum + b;
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_csum(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    #1;
    check("in_ready_forced_low", {31'h0, in_ready}, 32'h0);
    @(posedge clk);
    #1;
    load_start = 1'b0;
  endtask

  task automatic check_status(input string tag, input logic [4:0] c, input logic d,
                              input logic e, input logic run, input logic rdy);
    @(negedge clk);
    check({tag, "_count"},   {27'h0, count}, {27'h0, c});
    check({tag, "_done"},    {31'h0, done}, {31'h0, d});
    check({tag, "_err"},     {31'h0, err}, {31'h0, e});
    check({tag, "_cpu_run"}, {31'h0, cpu_run}, {31'h0, run});
    check({tag, "_in_ready"},{31'h0, in_ready}, {31'h0, rdy});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_im_we"},   {31'h0, im_we}, 32'h0);
    check({tag, "_im_addr"}, {28'h0, im_addr}, 32'h0);
    check({tag, "_im_data"}, {24'h0, im_data}, 32'h0);
    check({tag, "_cpu_run"}, {31'h0, cpu_run}, 32'h0);
    check({tag, "_done"},    {31'h0, done}, 32'h0);
    check({tag, "_err"},     {31'h0, err}, 32'h0);
    check({tag, "_count"},   {27'h0, count}, 32'h0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_busy", {31'h0, busy}, 32'h1);
    check("post_reset_in_ready", {31'h0, in_ready}, 32'h1);
    tick();

    // Good frame, back-to-back bytes
    send_len(8'h03);
    send_data(4'h0, 8'h11);
    send_data(4'h1, 8'h22);
    send_data(4'h2, 8'h33);
    check("good_cpu_run_before_csum", {31'h0, cpu_run}, 32'h0);
    send_csum(8'h00 - run_sum);
    check("good_cpu_run_next_cycle", {31'h0, cpu_run}, 32'h1);
    check("good_busy", {31'h0, busy}, 32'h0);
    check_status("good", 5'd3, 1'b1, 1'b0, 1'b1, 1'b0);

    // Bad checksum
    pulse_start();
    check_status("after_start", 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    send_len(8'h02);
    send_data(4'h0, 8'hA0);
    send_data(4'h1, 8'hB0);
    send_csum(8'h00);
    check_status("bad_csum", 5'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    pulse_start();
    check_status("bad_restart", 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Illegal lengths
    send_len(8'h00);
    check_status("len_zero", 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    pulse_start();
    send_len(8'h11);
    check_status("len_17", 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    pulse_start();

    // Full depth with stalls between bytes
    send_len(8'h10);
    for (int i = 0; i < 16; i++) begin
      tick();
      send_data(i[3:0], i[7:0]);
    end
    tick();
    send_csum(8'h00 - run_sum);
    check_status("full_depth", 5'd16, 1'b1, 1'b0, 1'b1, 1'b0);

    // Reload while running: byte offered alongside load_start is dropped
    load_start = 1'b1;
    in_valid   = 1'b1;
    in_data    = 8'h05;
    #1;
    check("reload_in_ready", {31'h0, in_ready}, 32'h0);
    check("reload_cpu_run_still_high", {31'h0, cpu_run}, 32'h1);
    @(posedge clk);
    #1;
    load_start = 1'b0;
    in_valid   = 1'b0;
    check_status("reload", 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("reload_busy", {31'h0, busy}, 32'h1);
    send_len(8'h02);
    send_data(4'h0, 8'h05);
    send_data(4'h1, 8'h06);
    send_csum(8'h00 - run_sum);
    check_status("reload_frame", 5'd2, 1'b1, 1'b0, 1'b1, 1'b0);

    // Reset mid-frame after 2 of 4 data bytes
    pulse_start();
    send_len(8'h04);
    send_data(4'h0, 8'hAA);
    send_data(4'h1, 8'hBB);
    tick();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    tick();
    rst_n = 1'b1;
    send_len(8'h01);
    send_data(4'h0, 8'h5A);
    send_csum(8'h00 - run_sum);
    check_status("fresh_frame", 5'd1, 1'b1, 1'b0, 1'b1, 1'b0);

    repeat (2) tick();
    check("scoreboard_drained", exp_q.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
